// File: rtl/board_eval.sv
// Board evaluator: scores contiguous 64-byte boards read over an Avalon-MM master, writes one
// score word per board and tracks the best board for the side to move.
module board_eval #(
  parameter int unsigned MAX_BOARDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  typedef enum logic [2:0] {
    StIdle, StRdReq, StRdWait, StAccum, StWrReq, StNext, StFinish
  } state_e;

  // Board count is 16 bits wide, so the clamp never needs more than 65535.
  localparam logic [16:0] MaxCnt = (MAX_BOARDS > 32'd65535) ? 17'd65535 : 17'(MAX_BOARDS);

  state_e      state_q, state_d;
  logic [31:0] src_q, src_d, dest_q, dest_d;
  logic [15:0] count_q, count_d;
  logic        side_q, side_d;
  logic [16:0] board_q, board_d;
  logic [5:0]  square_q, square_d;
  logic [31:0] score_q, score_d;
  logic [7:0]  code_q, code_d;
  logic [31:0] best_idx_q, best_idx_d, best_score_q, best_score_d;
  logic        done_q, done_d, err_q, err_d;
  logic        mst_read_q, mst_read_d, mst_write_q, mst_write_d;
  logic [31:0] mst_addr_q, mst_addr_d, mst_wdata_q, mst_wdata_d;

  logic        busy, start, better;
  logic [16:0] count_eff;
  logic [7:0]  code_mag;
  logic [31:0] mag_value, square_value;
  logic        code_bad;
  logic        unused_rdata;

  assign unused_rdata = ^master_readdata[31:8];
  assign busy      = (state_q != StIdle);
  assign start     = slave_write && !busy && (slave_address == 4'd0);
  assign count_eff = ({1'b0, count_q} > MaxCnt) ? MaxCnt : {1'b0, count_q};

  // Piece code to signed material value; out-of-range magnitudes score 0 and flag an error.
  always_comb begin
    code_mag  = code_q[7] ? (~code_q + 8'd1) : code_q;
    code_bad  = (code_mag > 8'd48);
    if (code_mag == 8'd0)       mag_value = 32'd0;
    else if (code_mag <= 8'd8)  mag_value = 32'd100;
    else if (code_mag <= 8'd18) mag_value = 32'd500;
    else if (code_mag <= 8'd28) mag_value = 32'd320;
    else if (code_mag <= 8'd38) mag_value = 32'd330;
    else if (code_mag <= 8'd47) mag_value = 32'd900;
    else if (code_mag == 8'd48) mag_value = 32'd20000;
    else                        mag_value = 32'd0;
    square_value = code_q[7] ? (~mag_value + 32'd1) : mag_value;
  end

  // Strict comparison against the running best, direction set by side.
  always_comb begin
    if (side_q) better = ($signed(score_q) < $signed(best_score_q));
    else        better = ($signed(score_q) > $signed(best_score_q));
  end

  // Register file writes, FSM next state and registered master outputs.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dest_d       = dest_q;
    count_d      = count_q;
    side_d       = side_q;
    board_d      = board_q;
    square_d     = square_q;
    score_d      = score_q;
    code_d       = code_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    done_d       = done_q;
    err_d        = err_q;

    if (slave_write && !busy) begin
      case (slave_address)
        4'd1:    src_d   = slave_writedata;
        4'd2:    count_d = slave_writedata[15:0];
        4'd3:    dest_d  = slave_writedata;
        4'd4:    side_d  = slave_writedata[0];
        default: ;
      endcase
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          done_d       = 1'b0;
          err_d        = 1'b0;
          best_idx_d   = 32'hFFFF_FFFF;
          best_score_d = 32'h8000_0000;
          board_d      = '0;
          square_d     = '0;
          score_d      = '0;
          state_d      = (count_eff == 17'd0) ? StFinish : StRdReq;
        end
      end
      StRdReq:  if (!master_waitrequest) state_d = StRdWait;
      StRdWait: begin
        if (master_readdatavalid) begin
          code_d  = master_readdata[7:0];
          state_d = StAccum;
        end
      end
      StAccum: begin
        score_d = score_q + square_value;
        if (code_bad) err_d = 1'b1;
        if (square_q == 6'd63) begin
          state_d = StWrReq;
        end else begin
          square_d = square_q + 6'd1;
          state_d  = StRdReq;
        end
      end
      StWrReq:  if (!master_waitrequest) state_d = StNext;
      StNext: begin
        // The first board is unconditionally best, so ties keep the earliest index.
        if (board_q == 17'd0 || better) begin
          best_idx_d   = 32'(board_q);
          best_score_d = score_q;
        end
        board_d = board_q + 17'd1;
        if (board_d == count_eff) begin
          state_d = StFinish;
        end else begin
          square_d = '0;
          score_d  = '0;
          state_d  = StRdReq;
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    mst_read_d  = (state_d == StRdReq);
    mst_write_d = (state_d == StWrReq);
    if (state_d == StRdReq)      mst_addr_d = src_q + 32'({board_d, square_d});
    else if (state_d == StWrReq) mst_addr_d = dest_q + 32'({board_d, 2'b00});
    else                         mst_addr_d = '0;
    mst_wdata_d = (state_d == StWrReq) ? score_d : '0;
  end

  // Slave read mux; only a status read during a run stalls.
  always_comb begin
    slave_waitrequest = slave_read && (slave_address == 4'd0) && busy;
    slave_readdata    = '0;
    if (slave_read) begin
      case (slave_address)
        4'd0:    slave_readdata = {30'b0, err_q, done_q};
        4'd1:    slave_readdata = src_q;
        4'd2:    slave_readdata = {16'b0, count_q};
        4'd3:    slave_readdata = dest_q;
        4'd4:    slave_readdata = {31'b0, side_q};
        4'd5:    slave_readdata = best_idx_q;
        4'd6:    slave_readdata = best_score_q;
        default: slave_readdata = '0;
      endcase
    end
  end

  assign master_read      = mst_read_q;
  assign master_write     = mst_write_q;
  assign master_address   = mst_addr_q;
  assign master_writedata = mst_wdata_q;

  // All state, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      src_q        <= '0;
      dest_q       <= '0;
      count_q      <= '0;
      side_q       <= 1'b0;
      board_q      <= '0;
      square_q     <= '0;
      score_q      <= '0;
      code_q       <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      mst_read_q   <= 1'b0;
      mst_write_q  <= 1'b0;
      mst_addr_q   <= '0;
      mst_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dest_q       <= dest_d;
      count_q      <= count_d;
      side_q       <= side_d;
      board_q      <= board_d;
      square_q     <= square_d;
      score_q      <= score_d;
      code_q       <= code_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      done_q       <= done_d;
      err_q        <= err_d;
      mst_read_q   <= mst_read_d;
      mst_write_q  <= mst_write_d;
      mst_addr_q   <= mst_addr_d;
      mst_wdata_q  <= mst_wdata_d;
    end
  end

endmodule
